// File: rtl/lis3dh_pkg.sv
// Shared constants, state encoding and SPI frame builders for the LIS3DH sequencer.
package lis3dh_pkg;

  localparam logic [5:0] CTRL_REG1 = 6'h20;
  localparam logic [5:0] CTRL_REG4 = 6'h23;
  localparam logic [5:0] OUT_X_L   = 6'h28;
  localparam logic [5:0] OUT_Y_L   = 6'h2A;
  localparam logic [5:0] OUT_Z_L   = 6'h2C;
  localparam logic [5:0] WHO_AM_I  = 6'h0F;

  localparam logic [7:0] WHO_AM_I_VAL = 8'h33;

  localparam logic RW_WRITE  = 1'b0;
  localparam logic RW_READ   = 1'b1;
  localparam logic MS_SINGLE = 1'b0;
  localparam logic MS_INC    = 1'b1;

  typedef enum logic [3:0] {
    IDLE, WHO_REQ, WHO_WAIT, CFG1_REQ, CFG1_WAIT, CFG4_REQ, CFG4_WAIT, WAIT_TICK,
    RDX_REQ, RDX_WAIT, RDY_REQ, RDY_WAIT, RDZ_REQ, RDZ_WAIT, PUBLISH, ERROR
  } state_t;

  function automatic logic [23:0] wr_frame(input logic [5:0] addr, input logic [7:0] val);
    return {RW_WRITE, MS_SINGLE, addr, val, 8'h00};
  endfunction

  function automatic logic [23:0] rd_frame(input logic [5:0] addr, input logic inc);
    return {RW_READ, inc, addr, 16'hFFFF};
  endfunction

endpackage

// File: rtl/lis3dh_tick_gen.sv
// Sample-rate divider: counts 0..SAMPLE_DIV-1 while run is high, pulses tick on the wrap cycle.
module lis3dh_tick_gen #(
  parameter int SAMPLE_DIV = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic tick
);
  localparam int CW = $clog2(SAMPLE_DIV);
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = run && (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      cnt <= '0;
    else if (clear) cnt <= '0;
    else if (run)   cnt <= tick ? '0 : cnt + CW'(1);
  end
endmodule

// File: rtl/lis3dh_ctrl.sv
// LIS3DH sequencer: configures the sensor, then reads X/Y/Z every SAMPLE_DIV clocks.
// Optional WHO_AM_I identity check at start-up when LIS3DH_WHOAMI_CHECK_EN is defined.
module lis3dh_ctrl
  import lis3dh_pkg::*;
#(
  parameter int         SAMPLE_DIV    = 100000,
  parameter logic [7:0] CTRL_REG1_VAL = 8'h97,
  parameter logic [7:0] CTRL_REG4_VAL = 8'h08,
  parameter int         SPI_TIMEOUT   = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [23:0] spi_data_tx,
  output logic        spi_tx_valid,
  input  logic        spi_done,
  input  logic [15:0] spi_data_rx,
  output logic [15:0] sample_x,
  output logic [15:0] sample_y,
  output logic [15:0] sample_z,
  output logic        sample_valid,
  output logic        configured,
  output logic        overrun,
  output logic        error
);
  localparam int TW = $clog2(SPI_TIMEOUT + 1);
`ifdef LIS3DH_WHOAMI_CHECK_EN
  localparam state_t FIRST_REQ = WHO_REQ;
`else
  localparam state_t FIRST_REQ = CFG1_REQ;
`endif

  state_t        state, state_nxt;
  logic          done_prev, done_rise, tick, tick_run, tick_clr;
  logic          is_req, is_wait, to_hit, cfg_done, err_set, frame_ld;
  logic [TW-1:0] to_cnt;
  logic [23:0]   frame_nxt;
  logic [15:0]   stg_x, stg_y, stg_z, rx_swap;

  assign done_rise    = spi_done & ~done_prev;
  assign rx_swap      = {spi_data_rx[7:0], spi_data_rx[15:8]};
  assign is_req       = state inside {WHO_REQ, CFG1_REQ, CFG4_REQ, RDX_REQ, RDY_REQ, RDZ_REQ};
  assign is_wait      = state inside {WHO_WAIT, CFG1_WAIT, CFG4_WAIT, RDX_WAIT, RDY_WAIT, RDZ_WAIT};
  assign to_hit       = is_wait && !done_rise && (to_cnt == TW'(SPI_TIMEOUT - 1));
  assign spi_tx_valid = is_req;
  assign frame_ld     = state_nxt inside {WHO_REQ, CFG1_REQ, CFG4_REQ, RDX_REQ, RDY_REQ, RDZ_REQ};
  assign tick_run     = configured && enable && (state != IDLE) && (state != ERROR);
  assign tick_clr     = (state == IDLE);

  lis3dh_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .run   (tick_run),
    .clear (tick_clr),
    .tick  (tick)
  );

  always_comb begin
    state_nxt = state;
    cfg_done  = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE:      if (enable) state_nxt = configured ? WAIT_TICK : FIRST_REQ;
`ifdef LIS3DH_WHOAMI_CHECK_EN
      WHO_REQ:   state_nxt = WHO_WAIT;
      WHO_WAIT:  if (done_rise) begin
                   if (spi_data_rx[15:8] != WHO_AM_I_VAL) begin
                     state_nxt = ERROR;
                     err_set   = 1'b1;
                   end else begin
                     state_nxt = enable ? CFG1_REQ : IDLE;
                   end
                 end
`endif
      CFG1_REQ:  state_nxt = CFG1_WAIT;
      CFG1_WAIT: if (done_rise) state_nxt = enable ? CFG4_REQ : IDLE;
      CFG4_REQ:  state_nxt = CFG4_WAIT;
      CFG4_WAIT: if (done_rise) begin
                   cfg_done  = 1'b1;
                   state_nxt = enable ? WAIT_TICK : IDLE;
                 end
      WAIT_TICK: if (!enable) state_nxt = IDLE;
                 else if (tick) state_nxt = RDX_REQ;
      RDX_REQ:   state_nxt = RDX_WAIT;
      RDX_WAIT:  if (done_rise) state_nxt = enable ? RDY_REQ : IDLE;
      RDY_REQ:   state_nxt = RDY_WAIT;
      RDY_WAIT:  if (done_rise) state_nxt = enable ? RDZ_REQ : IDLE;
      RDZ_REQ:   state_nxt = RDZ_WAIT;
      RDZ_WAIT:  if (done_rise) state_nxt = enable ? PUBLISH : IDLE;
      PUBLISH:   state_nxt = WAIT_TICK;
      ERROR:     state_nxt = ERROR;
      default:   state_nxt = IDLE;
    endcase
    // A stalled transaction overrides everything else.
    if (to_hit) begin
      state_nxt = ERROR;
      err_set   = 1'b1;
    end
  end

  always_comb begin
    frame_nxt = 24'h0;
    case (state_nxt)
      WHO_REQ:  frame_nxt = rd_frame(WHO_AM_I, MS_SINGLE);
      CFG1_REQ: frame_nxt = wr_frame(CTRL_REG1, CTRL_REG1_VAL);
      CFG4_REQ: frame_nxt = wr_frame(CTRL_REG4, CTRL_REG4_VAL);
      RDX_REQ:  frame_nxt = rd_frame(OUT_X_L, MS_INC);
      RDY_REQ:  frame_nxt = rd_frame(OUT_Y_L, MS_INC);
      RDZ_REQ:  frame_nxt = rd_frame(OUT_Z_L, MS_INC);
      default:  frame_nxt = 24'h0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      done_prev    <= 1'b0;
      to_cnt       <= '0;
      spi_data_tx  <= 24'h0;
      stg_x        <= '0;
      stg_y        <= '0;
      stg_z        <= '0;
      sample_x     <= '0;
      sample_y     <= '0;
      sample_z     <= '0;
      sample_valid <= 1'b0;
      configured   <= 1'b0;
      overrun      <= 1'b0;
      error        <= 1'b0;
    end else begin
      state        <= state_nxt;
      done_prev    <= spi_done;
      sample_valid <= (state == PUBLISH);
      // to_cnt holds clocks elapsed since the request cycle.
      if (is_req)       to_cnt <= TW'(1);
      else if (is_wait) to_cnt <= to_cnt + TW'(1);
      if (frame_ld) spi_data_tx <= frame_nxt;
      if (done_rise) begin
        case (state)
          RDX_WAIT: stg_x <= rx_swap;
          RDY_WAIT: stg_y <= rx_swap;
          RDZ_WAIT: stg_z <= rx_swap;
          default: ;
        endcase
      end
      if (state == PUBLISH) begin
        sample_x <= stg_x;
        sample_y <= stg_y;
        sample_z <= stg_z;
      end
      if (cfg_done) configured <= 1'b1;
      if (tick && (state != WAIT_TICK)) overrun <= 1'b1;
      if (err_set) error <= 1'b1;
    end
  end
endmodule
